// File: rtl/gray_video_pkg.sv
// Shared types and default VGA 640x480 timing for the gray frame generator.
package gray_video_pkg;

    localparam int unsigned CNT_W = 12;

    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_e;

    // One timing-decode sample as it travels through the alignment pipeline.
    typedef struct packed {
        logic             vsync;
        logic             hsync;
        logic             active;
        logic             start;
        logic [CNT_W-1:0] xpos;
        logic [CNT_W-1:0] ypos;
    } disp_t;

endpackage

// File: rtl/gray_frame_gen_sync_delay_line.sv
// Reset-to-zero shift pipeline of configurable width and depth.
module sync_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/gray_frame_gen.sv
// Gray-scale video timing generator with upstream pixel fetch and aligned outputs.
// Define TEST_PATTERN_EN to replace pixel_data with an x+y+frame diagonal pattern.
module gray_frame_gen
    import gray_video_pkg::*;
#(
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       pixel_data,
    output logic             pixel_req,
    output logic             frame_vsync,
    output logic             frame_hsync,
    output logic             frame_de,
    output logic [7:0]       color,
    output logic [CNT_W-1:0] pixel_xpos,
    output logic [CNT_W-1:0] pixel_ypos,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_last, frame_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        h_last     = (h_q == H_LAST);
        frame_last = h_last && (v_q == V_LAST);

        if (state_q != IDLE) begin
            if (h_last) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        // A frame only continues past its last position if enable is high there.
        case (state_q)
            IDLE:      if (enable) state_d = RUN;
            RUN:       if (!enable) state_d = frame_last ? IDLE : STOP_PEND;
            STOP_PEND: begin
                if (enable)          state_d = RUN;
                else if (frame_last) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    disp_t raw, s2, out;
    logic  running;

    always_comb begin
        running    = (state_q != IDLE);
        raw        = '0;
        raw.hsync  = running && (h_q < H_SYNC_C);
        raw.vsync  = running && (v_q < V_SYNC_C);
        raw.active = running && (h_q >= H_ACT_BEG) && (h_q <= H_ACT_LAST)
                             && (v_q >= V_ACT_BEG) && (v_q <= V_ACT_LAST);
        raw.start  = running && (h_q == '0) && (v_q == '0);
        if (raw.active) begin
            raw.xpos = h_q - H_ACT_BEG;
            raw.ypos = v_q - V_ACT_BEG;
        end
    end

    sync_delay_line #(.WIDTH(1), .DEPTH(1)) u_req_dly (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (raw.active),
        .q_o    (pixel_req)
    );

    // Split 2+1 so the colour register can see the stage that lines up with pixel_data.
    sync_delay_line #(.WIDTH($bits(disp_t)), .DEPTH(2)) u_pre_dly (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (raw),
        .q_o    (s2)
    );

    sync_delay_line #(.WIDTH($bits(disp_t)), .DEPTH(1)) u_out_dly (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (s2),
        .q_o    (out)
    );

    logic [7:0] color_q, color_d;

`ifdef TEST_PATTERN_EN
    logic [7:0] frame_cnt_q;
    logic       started_q;
    logic       unused_pixel_data;

    assign unused_pixel_data = ^pixel_data;

    // The first frame after reset is frame 0; each later frame start advances the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            started_q   <= 1'b0;
        end else if (s2.start) begin
            started_q <= 1'b1;
            if (started_q) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    always_comb begin
        color_d = '0;
        if (s2.active) color_d = 8'(s2.xpos + s2.ypos) + frame_cnt_q;
    end
`else
    always_comb begin
        color_d = '0;
        if (s2.active) color_d = pixel_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) color_q <= '0;
        else        color_q <= color_d;
    end

    assign frame_vsync = out.vsync;
    assign frame_hsync = out.hsync;
    assign frame_de    = out.active;
    assign frame_start = out.start;
    assign pixel_xpos  = out.xpos;
    assign pixel_ypos  = out.ypos;
    assign color       = color_q;

endmodule

// File: tb/tb_gray_frame_gen.sv
// Randomised bench for gray_frame_gen against a frame-position reference model.
module tb_gray_frame_gen;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  pixel_data = '0;
    logic        pixel_req, frame_vsync, frame_hsync, frame_de, frame_start;
    logic [7:0]  color;
    logic [11:0] pixel_xpos, pixel_ypos;

    gray_frame_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pixel_data  (pixel_data),
        .pixel_req   (pixel_req),
        .frame_vsync (frame_vsync),
        .frame_hsync (frame_hsync),
        .frame_de    (frame_de),
        .color       (color),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vs, hs, de, st;
        int x, y;
    } rec_t;

    rec_t hist[$];
    int   n_tests = 0;
    int   n_fail = 0;
    bit   m_run;
    int   m_pos;
    int   de_idx;
    int   cyc = 0;
    int   last_fs;
    int   de_in_frame;
    bit   chk_period = 0;
    bit   m_seen;
    int   m_fidx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic rec_t decode(input bit run, input int pos);
        rec_t r;
        int h, v;
        r = '{default: 0};
        if (!run) return r;
        h = pos % HT;
        v = pos / HT;
        r.hs = (h < 2);
        r.vs = (v < 1);
        r.de = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
        r.st = (pos == 0);
        if (r.de) begin
            r.x = h - 4;
            r.y = v - 2;
        end
        return r;
    endfunction

    // Upstream source: answers each pixel_req one cycle later with a running count.
    initial begin
        int  cnt;
        bit  pend;
        cnt = 0;
        forever begin
            @(negedge clk);
            pend = rst_n && pixel_req;
            @(posedge clk);
            #1;
            if (!rst_n) cnt = 0;
            if (pend) begin
                pixel_data = 8'(cnt);
                cnt++;
            end
        end
    end

    task automatic model_clear();
        rec_t z;
        z = '{default: 0};
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
        m_run = 0;
        m_pos = 0;
        de_idx = 0;
        last_fs = -1;
        de_in_frame = 0;
        m_seen = 0;
        m_fidx = 0;
    endtask

    task automatic tick(input bit en);
        rec_t e;
        bit   exp_req;
        int   exp_col;
        enable = en;
        hist.push_back(decode(m_run, m_pos));
        exp_req = hist[$].de;
        // A frame continues past its last cycle only if enable is high on that cycle.
        if (!m_run) begin
            if (en) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (m_pos == FR - 1) begin
            m_pos = 0;
            m_run = en;
        end else begin
            m_pos++;
        end
        @(posedge clk);
        #1;
        cyc++;
        e = hist[$-2];
        while (hist.size() > 3) void'(hist.pop_front());
        if (e.st) begin
            if (m_seen) m_fidx++;
            m_seen = 1;
        end
        exp_col = 0;
        if (e.de) begin
`ifdef TEST_PATTERN_EN
            exp_col = (e.x + e.y + m_fidx) & 255;
`else
            exp_col = de_idx & 255;
`endif
            de_idx++;
        end
        check("pixel_req", pixel_req, exp_req);
        check("vsync", frame_vsync, e.vs);
        check("hsync", frame_hsync, e.hs);
        check("de", frame_de, e.de);
        check("start", frame_start, e.st);
        check("xpos", pixel_xpos, e.x);
        check("ypos", pixel_ypos, e.y);
        check("color", color, exp_col);
        if (frame_start) begin
            if (chk_period && last_fs >= 0) begin
                check("fs_period", cyc - last_fs, FR);
                check("de_per_frame", de_in_frame, 32);
            end
            last_fs = cyc;
            de_in_frame = 0;
        end
        if (frame_de) de_in_frame++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {pixel_req, frame_vsync, frame_hsync, frame_de, frame_start},
              0);
        check({tag, "_color"}, color, 0);
        check({tag, "_xy"}, {pixel_xpos, pixel_ypos}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_now");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic run_until_pos(input int pos, input int budget);
        int n;
        n = 0;
        while (!(m_run && m_pos == pos) && n < budget) begin
            tick(1);
            n++;
        end
        check("reach_pos", (m_run && m_pos == pos), 1);
    endtask

    initial begin
        int n;
        int fs_cnt;

        do_reset();

        // Continuous run: period, line structure and data ordering.
        chk_period = 1;
        repeat (3 * FR + 20) tick(1);

        // Stop request mid-frame: frame completes then everything goes quiet.
        run_until_pos(40, 2 * FR);
        fs_cnt = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick(0);
            if (frame_start) fs_cnt++;
        end
        check("stop_no_fs", fs_cnt, 0);
        check_all_zero("stopped");

        // Drop and reassert within the same frame: no gap between frame starts.
        last_fs = -1;
        run_until_pos(40, 2 * FR);
        repeat (20) tick(0);
        repeat (2 * FR + 10) tick(1);

        // Reset mid active line, then restart.
        chk_period = 0;
        run_until_pos(2 * HT + 6, 2 * FR);
        do_reset();
        n = 0;
        while (n < 20) begin
            tick(1);
            n++;
            if (frame_start) break;
        end
        check("fs_after_release", n, 4);
        repeat (FR + 30) tick(1);

        // Random enable phases.
        for (int p = 0; p < 24; p++) begin
            bit en;
            int len;
            en  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 150);
            repeat (len) tick(en);
        end
        repeat (2 * FR) tick(0);
        check_all_zero("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
